// File: rtl/alu_pipe.sv
// ---------------------------------------------------------------------------
// alu_pipe: registered ALU with a valid/ready handshake on both sides.
//
// Optional multiplier: define ALU_MUL_EN to build the iterative shift-add
// multiplier (opcode 9, WIDTH+1 cycles from accept to result). Without it,
// opcode 9 completes in one cycle and is flagged illegal.
//
// Handshake rule: a transfer happens on a rising edge where valid && ready
// are both high. The producer holds its payload stable while valid is high
// and ready is low. The same rule applies to in_* (decode -> ALU) and
// out_* (ALU -> writeback).
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   in_valid / in_ready   command handshake
//   command               0 ADD 1 SUB 2 XOR 3 SLT 4 AND 5 NAND 6 NOR 7 OR
//                         8 SLTU 9 MUL, 10-15 illegal
//   operandA, operandB    operands, captured on accept
//   out_valid / out_ready result handshake
//   result, carryout, overflow, zero, illegal   registered result and flags
//   fsm_state             debug view of the FSM (0 IDLE, 1 MUL_BUSY)
// ---------------------------------------------------------------------------
module alu_pipe #(
  parameter int WIDTH = 32,
  parameter int CMD_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CMD_W-1:0] command,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             overflow,
  output logic             zero,
  output logic             illegal,
  output logic             fsm_state
);

  localparam logic [CMD_W-1:0] OP_ADD  = CMD_W'(0);
  localparam logic [CMD_W-1:0] OP_SUB  = CMD_W'(1);
  localparam logic [CMD_W-1:0] OP_XOR  = CMD_W'(2);
  localparam logic [CMD_W-1:0] OP_SLT  = CMD_W'(3);
  localparam logic [CMD_W-1:0] OP_AND  = CMD_W'(4);
  localparam logic [CMD_W-1:0] OP_NAND = CMD_W'(5);
  localparam logic [CMD_W-1:0] OP_NOR  = CMD_W'(6);
  localparam logic [CMD_W-1:0] OP_OR   = CMD_W'(7);
  localparam logic [CMD_W-1:0] OP_SLTU = CMD_W'(8);
  localparam logic [CMD_W-1:0] OP_MUL  = CMD_W'(9);

`ifdef ALU_MUL_EN
  localparam logic MUL_BUILT = 1'b1;
`else
  localparam logic MUL_BUILT = 1'b0;
`endif

  typedef enum logic {
    IDLE     = 1'b0,
    MUL_BUSY = 1'b1
  } state_t;

  state_t state, next_state;

  logic             accept;
  logic             out_fire;
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_lo;
  logic [WIDTH-1:0] mul_hi;

  assign accept   = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // -------------------------------------------------------------------------
  // Single-cycle datapath
  // -------------------------------------------------------------------------
  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic             add_ovf;
  logic             sub_ovf;
  logic [WIDTH-1:0] alu_res;
  logic             alu_cout;
  logic             alu_ovf;
  logic             alu_ill;

  always_comb begin
    add_full = {1'b0, operandA} + {1'b0, operandB};
    sub_full = {1'b0, operandA} + {1'b0, ~operandB} + (WIDTH+1)'(1);
    add_ovf  = (operandA[WIDTH-1] == operandB[WIDTH-1]) &&
               (add_full[WIDTH-1] != operandA[WIDTH-1]);
    sub_ovf  = (operandA[WIDTH-1] != operandB[WIDTH-1]) &&
               (sub_full[WIDTH-1] != operandA[WIDTH-1]);

    alu_res  = '0;
    alu_cout = 1'b0;
    alu_ovf  = 1'b0;
    alu_ill  = 1'b0;
    case (command)
      OP_ADD: begin
        alu_res  = add_full[WIDTH-1:0];
        alu_cout = add_full[WIDTH];
        alu_ovf  = add_ovf;
      end
      OP_SUB: begin
        alu_res  = sub_full[WIDTH-1:0];
        alu_cout = sub_full[WIDTH];
        alu_ovf  = sub_ovf;
      end
      OP_XOR:  alu_res = operandA ^ operandB;
      // Sign of the difference corrected by overflow gives the true signed
      // comparison even when A-B wraps.
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, sub_full[WIDTH-1] ^ sub_ovf};
      OP_AND:  alu_res = operandA & operandB;
      OP_NAND: alu_res = ~(operandA & operandB);
      OP_NOR:  alu_res = ~(operandA | operandB);
      OP_OR:   alu_res = operandA | operandB;
      // Borrow out of A-B means A < B unsigned.
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, ~sub_full[WIDTH]};
      // With the multiplier built, this path is unused for opcode 9.
      OP_MUL:  alu_ill = ~MUL_BUILT;
      default: alu_ill = 1'b1;
    endcase
  end

  // -------------------------------------------------------------------------
  // Iterative multiplier
  // -------------------------------------------------------------------------
`ifdef ALU_MUL_EN
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [CNT_W-1:0]   mul_cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;

  assign mul_start = accept && (command == OP_MUL);
  // WIDTH cycles consume the multiplier bits; the following cycle hands the
  // product to the output register.
  assign mul_done  = (state == MUL_BUSY) && (mul_cnt == CNT_W'(WIDTH));
  assign mul_lo    = acc[WIDTH-1:0];
  assign mul_hi    = acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mul_cnt <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
    end else if (mul_start) begin
      mul_cnt <= '0;
      acc     <= '0;
      mcand   <= {{WIDTH{1'b0}}, operandA};
      mplier  <= operandB;
    end else if ((state == MUL_BUSY) && !mul_done) begin
      if (mplier[0]) begin
        acc <= acc + mcand;
      end
      mcand   <= mcand << 1;
      mplier  <= mplier >> 1;
      mul_cnt <= mul_cnt + CNT_W'(1);
    end
  end
`else
  assign mul_start = 1'b0;
  assign mul_done  = 1'b0;
  assign mul_lo    = '0;
  assign mul_hi    = '0;
`endif

  // -------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (mul_start) next_state = MUL_BUSY;
      MUL_BUSY: if (mul_done)  next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE) && (!out_valid || out_ready);
    fsm_state = state;
  end

  // -------------------------------------------------------------------------
  // Output register: loads on a single-cycle accept or on multiply finish,
  // otherwise holds until the consumer takes it.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      carryout  <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      illegal   <= 1'b0;
    end else if (accept && !mul_start) begin
      out_valid <= 1'b1;
      result    <= alu_res;
      carryout  <= alu_cout;
      overflow  <= alu_ovf;
      zero      <= (alu_res == '0);
      illegal   <= alu_ill;
    end else if (mul_done) begin
      out_valid <= 1'b1;
      result    <= mul_lo;
      carryout  <= 1'b0;
      overflow  <= |mul_hi;
      zero      <= (mul_lo == '0);
      illegal   <= 1'b0;
    end else if (out_fire) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// ---------------------------------------------------------------------------
// tb_alu_pipe: directed bench for alu_pipe at WIDTH=32 and WIDTH=8.
// Expected responses are packed as {illegal, zero, overflow, carryout,
// result} and queued when a command is issued; a monitor pops and compares
// whenever the DUT hands over a result.
// ---------------------------------------------------------------------------
module tb_alu_pipe;

  localparam int W  = 32;
  localparam int W8 = 8;

`ifdef ALU_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, XOR = 4'd2, SLT = 4'd3;
  localparam logic [3:0] AND = 4'd4, NAND = 4'd5, NOR = 4'd6, OR = 4'd7;
  localparam logic [3:0] SLTU = 4'd8, MUL = 4'd9, BAD = 4'd12;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  // ---------------- WIDTH=32 DUT ----------------
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [3:0]    command;
  logic [W-1:0]  op_a, op_b, result;
  logic          carryout, overflow, zero, illegal, fsm_state;

  alu_pipe #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .command(command),
    .operandA(op_a), .operandB(op_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .carryout(carryout), .overflow(overflow), .zero(zero),
    .illegal(illegal), .fsm_state(fsm_state)
  );

  // ---------------- WIDTH=8 DUT ----------------
  logic          in_valid8, in_ready8, out_valid8, out_ready8;
  logic [3:0]    command8;
  logic [W8-1:0] op_a8, op_b8, result8;
  logic          carryout8, overflow8, zero8, illegal8, fsm_state8;

  alu_pipe #(.WIDTH(W8)) dut8 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid8), .in_ready(in_ready8), .command(command8),
    .operandA(op_a8), .operandB(op_b8),
    .out_valid(out_valid8), .out_ready(out_ready8), .result(result8),
    .carryout(carryout8), .overflow(overflow8), .zero(zero8),
    .illegal(illegal8), .fsm_state(fsm_state8)
  );

  // ---------------- scoreboard ----------------
  logic [W+3:0]  exp_q[$];
  logic [W8+3:0] exp8_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out32", {illegal, zero, overflow, carryout, result}, 72'h0);
        if ({illegal, zero, overflow, carryout, result} == '0) begin
          n_fail++;
          $display("FAIL unexpected_out32: got output with empty queue, expected none");
        end
      end else begin
        check("out32", {illegal, zero, overflow, carryout, result}, exp_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n && out_valid8 && out_ready8) begin
      if (exp8_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_out8: got %0h expected none",
                 {illegal8, zero8, overflow8, carryout8, result8});
      end else begin
        check("out8", {illegal8, zero8, overflow8, carryout8, result8}, exp8_q.pop_front());
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents a command, waits (bounded) for acceptance, returns #1 after
  // the accepting edge with in_valid dropped.
  task automatic issue(input logic [3:0] cmd, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W+3:0] exp, input bit push);
    int guard = 0;
    command  = cmd;
    op_a     = a;
    op_b     = b;
    in_valid = 1'b1;
    if (push) exp_q.push_back(exp);
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) check("accept_timeout32", 1'b0, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op_a     = $urandom;
    op_b     = $urandom;
  endtask

  task automatic issue8(input logic [3:0] cmd, input logic [W8-1:0] a, input logic [W8-1:0] b,
                        input logic [W8+3:0] exp);
    int guard = 0;
    command8  = cmd;
    op_a8     = a;
    op_b8     = b;
    in_valid8 = 1'b1;
    exp8_q.push_back(exp);
    @(negedge clk);
    while (!in_ready8 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) check("accept_timeout8", 1'b0, 1'b1);
    @(posedge clk);
    #1;
    in_valid8 = 1'b0;
    op_a8     = W8'($urandom_range(0, 255));
    op_b8     = W8'($urandom_range(0, 255));
  endtask

  // Issues a command and counts cycles from the accepting edge to the
  // first cycle out_valid is seen; in_ready must stay low meanwhile.
  task automatic timed_issue(input logic [3:0] cmd, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W+3:0] exp, input int exp_lat);
    int lat = 1;
    issue(cmd, a, b, exp, 1'b1);
    @(negedge clk);
    while (!out_valid && lat < 200) begin
      check("busy_in_ready", in_ready, 1'b0);
      @(negedge clk);
      lat++;
    end
    check("latency", lat, exp_lat);
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    in_valid = 0; command = 0; op_a = 0; op_b = 0; out_ready = 1;
    in_valid8 = 0; command8 = 0; op_a8 = 0; op_b8 = 0; out_ready8 = 1;
    reset_n = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset32", {out_valid, illegal, zero, overflow, carryout, result}, 72'h0);
    check("reset8", {out_valid8, illegal8, zero8, overflow8, carryout8, result8}, 72'h0);
    check("reset_in_ready", in_ready, 1'b1);
    reset_n = 1;
    idle(1);

    // Back-to-back single-cycle ops; {illegal,zero,ovf,cout,result}
    issue(ADD,  32'd2,        32'd1,        {4'b0000, 32'd3},         1);
    issue(SUB,  32'd4,        32'd2,        {4'b0001, 32'd2},         1);
    issue(SUB,  32'd2,        32'd4,        {4'b0000, 32'hFFFF_FFFE}, 1);
    issue(SUB,  32'd5,        32'd5,        {4'b0101, 32'd0},         1);
    issue(ADD,  32'h7FFF_FFFF, 32'd1,       {4'b0010, 32'h8000_0000}, 1);
    issue(SLT,  32'h8000_0000, 32'd1,       {4'b0000, 32'd1},         1);
    issue(SLTU, 32'h8000_0000, 32'd1,       {4'b0100, 32'd0},         1);
    issue(SLT,  32'd1,        32'h8000_0000, {4'b0100, 32'd0},        1);
    issue(SLTU, 32'd1,        32'h8000_0000, {4'b0000, 32'd1},        1);
    issue(ADD,  32'hFFFF_FFFB, 32'hFFFF_FFF9, {4'b0001, 32'hFFFF_FFF4}, 1);
    issue(XOR,  32'hF0F0_F0F0, 32'h0FF0_0FF0, {4'b0000, 32'hFF00_FF00}, 1);
    issue(AND,  32'hF0F0_F0F0, 32'h0FF0_0FF0, {4'b0000, 32'h00F0_00F0}, 1);
    issue(NAND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, {4'b0000, 32'hFF0F_FF0F}, 1);
    issue(NOR,  32'hF0F0_F0F0, 32'h0FF0_0FF0, {4'b0000, 32'h000F_000F}, 1);
    issue(OR,   32'hF0F0_F0F0, 32'h0FF0_0FF0, {4'b0000, 32'hFFF0_FFF0}, 1);
    issue(BAD,  32'd3,        32'd4,        {4'b1100, 32'd0},         1);
    idle(1);

    // Multiply: latency and in_ready low while busy
    timed_issue(MUL, 32'h1_0000, 32'h1_0000,
                MUL_ON ? {4'b0110, 32'd0} : {4'b1100, 32'd0}, MUL_ON ? 33 : 1);
    timed_issue(MUL, 32'd7, 32'd6,
                MUL_ON ? {4'b0000, 32'd42} : {4'b1100, 32'd0}, MUL_ON ? 33 : 1);
    timed_issue(ADD, 32'd10, 32'd20, {4'b0000, 32'd30}, 1);

    // Backpressure: result held while out_ready is low
    out_ready = 0;
    issue(ADD, 32'd2, 32'd1, {4'b0000, 32'd3}, 1);
    repeat (3) begin
      @(negedge clk);
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_result", result, 32'd3);
      check("bp_in_ready", in_ready, 1'b0);
    end
    @(posedge clk);
    #1;
    out_ready = 1;
    command   = XOR;
    op_a      = 32'd4;
    op_b      = 32'd2;
    in_valid  = 1;
    exp_q.push_back({4'b0000, 32'd6});
    @(negedge clk);
    check("dual_hs", {in_ready, out_valid}, 2'b11);
    @(posedge clk);
    #1;
    in_valid = 0;
    @(negedge clk);
    check("after_dual_hs", {out_valid, result}, {1'b1, 32'd6});
    idle(2);

    // Reset in the middle of a multiply
    issue(ADD, 32'd2, 32'd1, {4'b0000, 32'd3}, 1);
    idle(1);
    issue(MUL, 32'd3, 32'd5, {4'b1100, 32'd0}, !MUL_ON);
    repeat (9) @(posedge clk);
    #2;
    reset_n = 0;
    #1;
    check("midmul_reset_out", {out_valid, illegal, zero, overflow, carryout, result}, 72'h0);
    check("midmul_reset_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    reset_n = 1;
    check("post_reset_in_ready", in_ready, 1'b1);
    issue(ADD, 32'd1, 32'd1, {4'b0000, 32'd2}, 1);
    idle(2);

    // WIDTH=8 instance
    issue8(ADD, 8'h7F, 8'h01, {4'b0010, 8'h80});
    issue8(SUB, 8'h04, 8'h02, {4'b0001, 8'h02});
    issue8(SUB, 8'h02, 8'h04, {4'b0000, 8'hFE});
    issue8(SUB, 8'h05, 8'h05, {4'b0101, 8'h00});
    issue8(SUB, 8'h80, 8'h01, {4'b0011, 8'h7F});
    issue8(ADD, 8'hFB, 8'hF9, {4'b0001, 8'hF4});
    issue8(SLT, 8'h80, 8'h01, {4'b0000, 8'h01});
    issue8(SLTU, 8'h80, 8'h01, {4'b0100, 8'h00});
    issue8(MUL, 8'h10, 8'h10, MUL_ON ? {4'b0110, 8'h00} : {4'b1100, 8'h00});
    issue8(MUL, 8'h0D, 8'h0B, MUL_ON ? {4'b0000, 8'h8F} : {4'b1100, 8'h00});
    idle(MUL_ON ? 12 : 2);

    check("queue32_drained", exp_q.size(), 0);
    check("queue8_drained", exp8_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, registered successor to the 32-bit combinational ALU.
- Keeps the eight existing opcodes and adds SLTU and an iterative shift-add multiply.
- Input and output use valid/ready handshakes, so the block can sit between the decode stage and the writeback buffer of the datapath.
- Single-cycle ops complete in 1 cycle; MUL takes WIDTH+1 cycles.

Parameters:
WIDTH, 32, operand/result width in bits (legal 4..64)
CMD_W, 4, command field width (fixed at 4; do not override)

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous, active-low reset
in_valid  input  1  operands/command valid
in_ready  output  1  block can accept a new command this cycle
command  input  CMD_W  0 ADD, 1 SUB, 2 XOR, 3 SLT, 4 AND, 5 NAND, 6 NOR, 7 OR, 8 SLTU, 9 MUL, 10-15 illegal
operandA  input  WIDTH  first operand
operandB  input  WIDTH  second operand
out_valid  output  1  result/flags valid
out_ready  input  1  consumer accepts result
result  output  WIDTH  registered result
carryout  output  1  adder carry out
overflow  output  1  signed overflow (ADD/SUB), upper-half-nonzero (MUL)
zero  output  1  result == 0
illegal  output  1  command was illegal (or MUL when compiled out)

Behaviour:
- Reset (reset_n low, async): state=IDLE, out_valid=0, result=0, carryout=0, overflow=0, zero=0, illegal=0.
- Outputs are registered. in_ready = (state==IDLE) && (!out_valid || out_ready).
- Accept on in_valid && in_ready. Operands and command are captured that edge; later input changes are ignored.
- FSM states: IDLE, MUL_BUSY.
  - IDLE, accepted non-MUL: result/flags loaded; out_valid=1 next cycle.
  - IDLE, accepted MUL: go to MUL_BUSY; counter=0, acc=0.
  - MUL_BUSY: one multiplier bit per cycle, LSB first; acc is 2*WIDTH bits. After WIDTH cycles, load the low WIDTH bits into result, set out_valid, return to IDLE.
  - Latency from accept to out_valid: 1 cycle for non-MUL, WIDTH+1 cycles for MUL.
- Output holds result, flags and out_valid stable until out_valid && out_ready.
  - Accept and drain in the same cycle is legal: back-to-back single-cycle ops give 1 result per cycle.
- ADD:
  - {carryout,result} = A+B.
  - overflow = (A[msb]==B[msb]) && (result[msb]!=A[msb]).
- SUB:
  - {carryout,result} = A + ~B + 1; carryout=1 means no borrow.
  - overflow = (A[msb]!=B[msb]) && (result[msb]!=A[msb]).
- SLT: result = {0…,1} if signed A<B, computed as sub_msb XOR sub_overflow (correct under overflow); carryout=overflow=0.
- SLTU: result = {0…,1} if unsigned A<B (i.e. SUB carryout==0); carryout=overflow=0.
- XOR, AND, NAND, NOR, OR: bitwise ops; carryout=overflow=0.
- MUL:
  - Unsigned product; result = low WIDTH bits.
  - overflow = |high WIDTH bits; carryout=0.
- zero = (result==0) for every op, including SLT/SLTU and MUL low half.
- illegal=1 for opcodes 10-15; in that case result=0, zero=1, carryout=overflow=0. The op completes in 1 cycle like a normal op.
- Reset mid-MUL aborts immediately: IDLE, out_valid=0, partial product discarded.
- in_valid while in MUL_BUSY: in_ready=0, nothing captured.

Optional Feature:
ALU_MUL_EN
- Defined: MUL_BUSY state, shift-add datapath and counter are built; opcode 9 behaves as above.
- Undefined: no multiplier logic. Opcode 9 is handled as illegal (1-cycle, result=0, zero=1, illegal=1), and the FSM never leaves IDLE.

Test Plan:
- WIDTH=32, ADD A=2, B=1, out_ready=1 → next cycle out_valid=1, result=3, cout=0, ovf=0, zero=0.
- SUB A=4, B=2 → result=2, cout=1; SUB A=2, B=4 → result=0xFFFFFFFE, cout=0; SUB A=5, B=5 → result=0, zero=1.
- ADD A=0x7FFFFFFF, B=1 → result=0x80000000, ovf=1, cout=0.
  - SLT A=0x80000000, B=1 → result=1.
  - SLTU with the same operands → result=0.
  - ADD A=-5, B=-7 → result=-12, cout=1, ovf=0.
- With ALU_MUL_EN, MUL A=0x10000, B=0x10000 → out_valid exactly 33 cycles after accept, result=0, ovf=1, zero=1.
  - in_ready=0 throughout MUL_BUSY.
  - Without ALU_MUL_EN, the same op → 1 cycle, illegal=1.
- Backpressure: hold out_ready=0 after ADD 2+1 → result stays 3, in_ready=0.
  - Release out_ready while presenting XOR 4^2 → both handshakes complete in the same cycle.
  - Next cycle result=6.
- Assert reset_n=0 at cycle 10 of a MUL → all outputs 0 asynchronously.
  - After release, in_ready=1 and ADD 1+1 → result=2.
- Re-run the ADD/SUB/overflow scenarios at WIDTH=8: ADD 0x7F+0x01 → result=0x80, ovf=1.
